// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-write/single-read-port data RAM between the RV32I core
//   data bus (cpu_*) and the Avalon CSR host (host_*), with waitrequest
//   back-pressure on both sides and round-robin arbitration on contention.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_address/read/write/...   core Avalon-MM slave side (byte enables pass through)
//   cpu_readdata, cpu_waitrequest
//   host_address/read/write/...  CSR host Avalon-MM slave side (always full-word writes)
//   host_readdata, host_waitrequest
//   mem_wren/byteena/wraddress/data  RAM write port (word addressed)
//   mem_rdaddress, mem_q         RAM read port, one-cycle read latency
//   conflict_count               saturating count of cycles a requester was denied
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           cpu_address,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_writedata,
  input  logic [3:0]            cpu_byteenable,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_waitrequest,
  input  logic [31:0]           host_address,
  input  logic                  host_read,
  input  logic                  host_write,
  input  logic [31:0]           host_writedata,
  output logic [31:0]           host_readdata,
  output logic                  host_waitrequest,
  output logic                  mem_wren,
  output logic [3:0]            mem_byteena,
  output logic [ADDR_WIDTH-1:0] mem_wraddress,
  output logic [31:0]           mem_data,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress,
  input  logic [31:0]           mem_q,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_HOST} state_t;
  typedef enum logic {GNT_CPU, GNT_HOST} grant_t;

  state_t               r_state;
  state_t               w_next_state;
  grant_t               r_last_grant;
  grant_t               w_next_last_grant;
  logic [CNT_WIDTH-1:0] r_conflict_count;

  logic                  w_cpu_req;
  logic                  w_host_req;
  logic                  w_cpu_win;
  logic                  w_host_win;
  logic                  w_cpu_done;
  logic                  w_host_done;
  logic                  w_denied;
  logic [ADDR_WIDTH-1:0] w_cpu_word;
  logic [ADDR_WIDTH-1:0] w_host_word;
  logic                  w_unused_addr_bits;

  assign w_cpu_req   = cpu_read | cpu_write;
  assign w_host_req  = host_read | host_write;
  assign w_cpu_word  = cpu_address[ADDR_WIDTH+1:2];
  assign w_host_word = host_address[ADDR_WIDTH+1:2];

  // Upper and sub-word address bits are ignored: the RAM aliases modulo its size.
  assign w_unused_addr_bits = ^{cpu_address[31:ADDR_WIDTH+2], cpu_address[1:0],
                                host_address[31:ADDR_WIDTH+2], host_address[1:0]};

  // Grant decision. Held off combinationally while reset_n is low so that no
  // write strobe or grant escapes during reset.
  always_comb begin
    w_cpu_win  = 1'b0;
    w_host_win = 1'b0;
    if (reset_n && (r_state == IDLE)) begin
      if (w_cpu_req && (!w_host_req || (r_last_grant == GNT_HOST))) begin
        w_cpu_win = 1'b1;
      end else if (w_host_req) begin
        w_host_win = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_HOST;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
    end
  end

  // Next-state logic. A read-data state always lasts exactly one cycle.
  always_comb begin
    w_next_state      = IDLE;
    w_next_last_grant = r_last_grant;
    if (w_cpu_win) begin
      w_next_last_grant = GNT_CPU;
      if (!cpu_write) w_next_state = RD_CPU;
    end else if (w_host_win) begin
      w_next_last_grant = GNT_HOST;
      if (!host_write) w_next_state = RD_HOST;
    end
  end

  // Output logic
  always_comb begin
    mem_wren      = 1'b0;
    mem_byteena   = cpu_byteenable;
    mem_wraddress = w_cpu_word;
    mem_data      = cpu_writedata;
    mem_rdaddress = w_cpu_word;
    if (w_host_win) begin
      mem_byteena   = 4'b1111;
      mem_wraddress = w_host_word;
      mem_data      = host_writedata;
      mem_rdaddress = w_host_word;
      mem_wren      = host_write;
    end else if (w_cpu_win) begin
      mem_wren      = cpu_write;
    end

    w_cpu_done  = (w_cpu_win & cpu_write) | (r_state == RD_CPU);
    w_host_done = (w_host_win & host_write) | (r_state == RD_HOST);

    cpu_waitrequest  = w_cpu_req & ~w_cpu_done;
    host_waitrequest = w_host_req & ~w_host_done;

    // Only one requester can be denied in any cycle.
    w_denied = (w_cpu_win & w_host_req) | (w_host_win & w_cpu_req) |
               ((r_state == RD_CPU) & w_host_req) | ((r_state == RD_HOST) & w_cpu_req);
  end

  assign cpu_readdata  = mem_q;
  assign host_readdata = mem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_count <= '0;
    end else if (w_denied && (r_conflict_count != '1)) begin
      r_conflict_count <= r_conflict_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign conflict_count = r_conflict_count;

endmodule
